// File: rtl/decode_issue.sv
// Registered decode/issue stage: prioritised forwarding, load-use scoreboard, branch redirect; 1 cycle accept->issue.
// Output register holds while !out_ready; in_ready drops on hazard or flush. DECODE_STATS_EN builds the stat counters.
module decode_issue #(
    parameter int XLEN     = 64,
    parameter int NFWD     = 3,
    parameter int LOAD_LAT = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [XLEN-1:0]      in_pc,
    input  logic [4:0]           in_ra1,
    input  logic [4:0]           in_ra2,
    input  logic [4:0]           in_rd,
    input  logic                 in_regwrite,
    input  logic                 in_memread,
    input  logic                 in_branch,
    input  logic [1:0]           in_brop,
    input  logic [XLEN-1:0]      in_target,
    input  logic [XLEN-1:0]      rd1,
    input  logic [XLEN-1:0]      rd2,
    input  logic [NFWD-1:0]      fwd_valid,
    input  logic [5*NFWD-1:0]    fwd_wa,
    input  logic [XLEN*NFWD-1:0] fwd_data,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [XLEN-1:0]      out_pc,
    output logic [XLEN-1:0]      out_srca,
    output logic [XLEN-1:0]      out_srcb,
    output logic [4:0]           out_rd,
    output logic                 out_regwrite,
    output logic                 out_memread,
    output logic                 redirect,
    output logic [XLEN-1:0]      redirect_pc,
    output logic [31:0]          stat_issued,
    output logic [31:0]          stat_stalls
);
    localparam int SBW = (LOAD_LAT > 0) ? $clog2(LOAD_LAT + 1) : 1;

    logic            out_valid_q, out_regwrite_q, out_memread_q, redirect_q;
    logic [XLEN-1:0] out_pc_q, out_srca_q, out_srcb_q, redirect_pc_q;
    logic [4:0]      out_rd_q;
    logic [SBW-1:0]  sb_q [32];
    logic [SBW-1:0]  sb_d [32];
    logic [XLEN-1:0] opa, opb;
    logic            hz, taken, accept, depart;

    // Lowest-index matching channel wins, so scan from the highest index down and let lower ones overwrite.
    function automatic logic [XLEN-1:0] resolve(input logic [4:0] a, input logic [XLEN-1:0] rf,
                                                input logic [NFWD-1:0] v, input logic [5*NFWD-1:0] wa,
                                                input logic [XLEN*NFWD-1:0] d);
        logic [XLEN-1:0] r;
        r = rf;
        for (int i = NFWD - 1; i >= 0; i--) begin
            if (v[i] && wa[5*i +: 5] == a) r = d[XLEN*i +: XLEN];
        end
        if (a == 5'd0) r = '0;
        return r;
    endfunction

    assign opa = resolve(in_ra1, rd1, fwd_valid, fwd_wa, fwd_data);
    assign opb = resolve(in_ra2, rd2, fwd_valid, fwd_wa, fwd_data);

    always_comb begin
        hz = 1'b0;
        if (out_valid_q && out_memread_q && out_regwrite_q && out_rd_q != 5'd0 &&
            ((in_ra1 != 5'd0 && in_ra1 == out_rd_q) || (in_ra2 != 5'd0 && in_ra2 == out_rd_q)))
            hz = 1'b1;
        if (in_ra1 != 5'd0 && sb_q[in_ra1] != '0) hz = 1'b1;
        if (in_ra2 != 5'd0 && sb_q[in_ra2] != '0) hz = 1'b1;
    end

    assign in_ready = !hz && (!out_valid_q || out_ready) && !flush;
    assign accept   = in_valid && in_ready;
    assign depart   = out_valid_q && out_ready;

    always_comb begin
        case (in_brop)
            2'b00:   taken = 1'b1;
            2'b01:   taken = (opa == opb);
            2'b10:   taken = (opa != opb);
            default: taken = ($signed(opa) < $signed(opb));
        endcase
    end

    // A departing load re-arms its destination; LOAD_LAT=0 arms with zero, leaving only the held-load check.
    always_comb begin
        for (int r = 0; r < 32; r++) begin
            sb_d[r] = sb_q[r];
            if (r != 0) begin
                if (depart && out_memread_q && out_rd_q == 5'(r)) sb_d[r] = SBW'(LOAD_LAT);
                else if (sb_q[r] != '0)                            sb_d[r] = sb_q[r] - SBW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid_q    <= 1'b0;
            out_pc_q       <= '0;
            out_srca_q     <= '0;
            out_srcb_q     <= '0;
            out_rd_q       <= '0;
            out_regwrite_q <= 1'b0;
            out_memread_q  <= 1'b0;
            redirect_q     <= 1'b0;
            redirect_pc_q  <= '0;
            for (int r = 0; r < 32; r++) sb_q[r] <= '0;
        end else begin
            if (flush) begin
                out_valid_q <= 1'b0;
            end else if (accept) begin
                out_valid_q    <= 1'b1;
                out_pc_q       <= in_pc;
                out_srca_q     <= opa;
                out_srcb_q     <= opb;
                out_rd_q       <= in_rd;
                out_regwrite_q <= in_regwrite;
                out_memread_q  <= in_memread;
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end
            redirect_q <= accept && in_branch && taken;
            if (accept && in_branch && taken) redirect_pc_q <= in_target;
            sb_q <= sb_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_pc       = out_pc_q;
    assign out_srca     = out_srca_q;
    assign out_srcb     = out_srcb_q;
    assign out_rd       = out_rd_q;
    assign out_regwrite = out_regwrite_q;
    assign out_memread  = out_memread_q;
    assign redirect     = redirect_q;
    assign redirect_pc  = redirect_pc_q;

`ifdef DECODE_STATS_EN
    logic [31:0] issued_q, stalls_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            issued_q <= '0;
            stalls_q <= '0;
        end else begin
            if (accept && issued_q != 32'hFFFF_FFFF)                 issued_q <= issued_q + 32'd1;
            if (in_valid && !in_ready && stalls_q != 32'hFFFF_FFFF) stalls_q <= stalls_q + 32'd1;
        end
    end

    assign stat_issued = issued_q;
    assign stat_stalls = stalls_q;
`else
    assign stat_issued = '0;
    assign stat_stalls = '0;
`endif
endmodule

// File: tb/tb_decode_issue.sv
// Bench for decode_issue: directed vectors with literal checks plus a per-cycle behavioural model comparison.
module tb_decode_issue;
    localparam int XLEN = 64, NFWD = 3, LOAD_LAT = 1;

    logic              clk, reset, in_valid, in_ready;
    logic [XLEN-1:0]   in_pc, in_target, rd1, rd2;
    logic [4:0]        in_ra1, in_ra2, in_rd;
    logic              in_regwrite, in_memread, in_branch;
    logic [1:0]        in_brop;
    logic [NFWD-1:0]   fwd_valid;
    logic [5*NFWD-1:0] fwd_wa;
    logic [XLEN*NFWD-1:0] fwd_data;
    logic              flush, out_valid, out_ready;
    logic [XLEN-1:0]   out_pc, out_srca, out_srcb, redirect_pc;
    logic [4:0]        out_rd;
    logic              out_regwrite, out_memread, redirect;
    logic [31:0]       stat_issued, stat_stalls;

    decode_issue #(.XLEN(XLEN), .NFWD(NFWD), .LOAD_LAT(LOAD_LAT)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
        .in_ra1(in_ra1), .in_ra2(in_ra2), .in_rd(in_rd), .in_regwrite(in_regwrite),
        .in_memread(in_memread), .in_branch(in_branch), .in_brop(in_brop), .in_target(in_target),
        .rd1(rd1), .rd2(rd2), .fwd_valid(fwd_valid), .fwd_wa(fwd_wa), .fwd_data(fwd_data),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_srca(out_srca), .out_srcb(out_srcb), .out_rd(out_rd), .out_regwrite(out_regwrite),
        .out_memread(out_memread), .redirect(redirect), .redirect_pc(redirect_pc),
        .stat_issued(stat_issued), .stat_stalls(stat_stalls)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model state: what the outputs must show after the next rising edge.
    logic        m_vld, m_rw, m_mr, m_redir;
    logic [63:0] m_pc, m_a, m_b, m_rpc;
    logic [4:0]  m_rd;
    int          sb [32];
    longint      m_iss, m_stl;

    function automatic void clear_model();
        m_vld = 0; m_rw = 0; m_mr = 0; m_redir = 0;
        m_pc = 0; m_a = 0; m_b = 0; m_rpc = 0; m_rd = 0;
        m_iss = 0; m_stl = 0;
        for (int r = 0; r < 32; r++) sb[r] = 0;
    endfunction

    initial clear_model();

    function automatic logic [63:0] res(input logic [4:0] a, input logic [63:0] rf);
        if (a == 0) return 64'd0;
        for (int i = 0; i < NFWD; i++)
            if (fwd_valid[i] && fwd_wa[5*i +: 5] == a) return fwd_data[XLEN*i +: XLEN];
        return rf;
    endfunction

    always @(negedge reset) clear_model();

    always @(negedge clk) begin
        logic [63:0] a, b;
        logic hz, rdy, acc, dep, tk;
        if (!reset) begin
            clear_model();
        end else begin
            check("out_valid", out_valid, m_vld);
            check("out_pc", out_pc, m_pc);
            check("out_srca", out_srca, m_a);
            check("out_srcb", out_srcb, m_b);
            check("out_rd", out_rd, m_rd);
            check("out_regwrite", out_regwrite, m_rw);
            check("out_memread", out_memread, m_mr);
            check("redirect", redirect, m_redir);
            check("redirect_pc", redirect_pc, m_rpc);
`ifdef DECODE_STATS_EN
            check("stat_issued", stat_issued, m_iss[31:0]);
            check("stat_stalls", stat_stalls, m_stl[31:0]);
`else
            check("stat_issued", stat_issued, 64'd0);
            check("stat_stalls", stat_stalls, 64'd0);
`endif
            a = res(in_ra1, rd1);
            b = res(in_ra2, rd2);
            hz = (m_vld && m_mr && m_rw && m_rd != 0 && (in_ra1 == m_rd || in_ra2 == m_rd)) ||
                 (in_ra1 != 0 && sb[in_ra1] > 0) || (in_ra2 != 0 && sb[in_ra2] > 0);
            rdy = !hz && (!m_vld || out_ready) && !flush;
            check("in_ready", in_ready, rdy);
            acc = in_valid && rdy;
            dep = m_vld && out_ready;
            for (int r = 1; r < 32; r++) begin
                if (dep && m_mr && m_rd == r) sb[r] = LOAD_LAT;
                else if (sb[r] > 0)           sb[r] = sb[r] - 1;
            end
            case (in_brop)
                2'b00:   tk = 1;
                2'b01:   tk = (a == b);
                2'b10:   tk = (a != b);
                default: tk = ($signed(a) < $signed(b));
            endcase
            m_redir = acc && in_branch && tk;
            if (m_redir) m_rpc = in_target;
            if (flush) m_vld = 0;
            else if (acc) begin
                m_vld = 1; m_pc = in_pc; m_a = a; m_b = b;
                m_rd = in_rd; m_rw = in_regwrite; m_mr = in_memread;
            end else if (out_ready) m_vld = 0;
            if (acc && m_iss < 64'hFFFF_FFFF) m_iss++;
            if (in_valid && !rdy && m_stl < 64'hFFFF_FFFF) m_stl++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [63:0] pc, input logic [4:0] a1, input logic [4:0] a2,
                             input logic [4:0] d, input logic rw, input logic mr, input logic br,
                             input logic [1:0] op, input logic [63:0] tgt, input logic [63:0] r1,
                             input logic [63:0] r2);
        in_valid = 1; in_pc = pc; in_ra1 = a1; in_ra2 = a2; in_rd = d;
        in_regwrite = rw; in_memread = mr; in_branch = br; in_brop = op;
        in_target = tgt; rd1 = r1; rd2 = r2;
    endtask

    logic [1:0]  bt_op  [6] = '{2'b01, 2'b11, 2'b10, 2'b10, 2'b00, 2'b11};
    logic [63:0] bt_r1  [6] = '{64'h10, 64'hFFFF_FFFF_FFFF_FFFF, 64'd5, 64'd5, 64'd0, 64'd1};
    logic [63:0] bt_r2  [6] = '{64'h11, 64'd1, 64'd5, 64'd6, 64'd9, 64'hFFFF_FFFF_FFFF_FFFF};
    logic        bt_exp [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

    initial begin
        reset = 0; in_valid = 0; in_pc = 0; in_ra1 = 0; in_ra2 = 0; in_rd = 0;
        in_regwrite = 0; in_memread = 0; in_branch = 0; in_brop = 0; in_target = 0;
        rd1 = 0; rd2 = 0; fwd_valid = 0; fwd_wa = 0; fwd_data = 0; flush = 0; out_ready = 0;
        #2;
        check("reset_out_valid", out_valid, 0);
        check("reset_redirect", redirect, 0);
        check("reset_out_pc", out_pc, 0);
        check("reset_redirect_pc", redirect_pc, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1;

        // Forwarding priority
        out_ready = 1;
        fwd_valid = 3'b011;
        fwd_wa    = {5'd0, 5'd5, 5'd5};
        fwd_data  = {64'h0, 64'hBB, 64'hAA};
        set_instr(64'h10, 5'd5, 5'd0, 5'd1, 1, 0, 0, 2'b00, 64'd0, 64'hCC, 64'h77);
        #1 check("fwd_in_ready", in_ready, 1);
        step();
        check("fwd_pri_valid", out_valid, 1);
        check("fwd_pri_srca", out_srca, 64'hAA);
        check("fwd_pri_srcb_x0", out_srcb, 64'h0);
        set_instr(64'h14, 5'd0, 5'd0, 5'd1, 1, 0, 0, 2'b00, 64'd0, 64'hCC, 64'h77);
        step();
        check("fwd_x0_srca", out_srca, 64'h0);
        fwd_valid = 3'b100;
        fwd_wa    = {5'd5, 5'd0, 5'd0};
        fwd_data  = {64'hDD, 64'h0, 64'h0};
        set_instr(64'h18, 5'd9, 5'd5, 5'd1, 1, 0, 0, 2'b00, 64'd0, 64'h1234, 64'h77);
        step();
        check("fwd_ch2_srcb", out_srcb, 64'hDD);
        check("fwd_rf_srca", out_srca, 64'h1234);
        fwd_valid = 0; in_valid = 0;
        step();

        // Backpressure and back-to-back refill
        set_instr(64'h100, 5'd1, 5'd2, 5'd3, 1, 0, 0, 2'b00, 64'd0, 64'd1, 64'd2);
        step();
        out_ready = 0;
        set_instr(64'h104, 5'd1, 5'd2, 5'd4, 1, 0, 0, 2'b00, 64'd0, 64'd3, 64'd4);
        for (int i = 0; i < 4; i++) begin
            #1;
            check("bp_in_ready", in_ready, 0);
            check("bp_hold_pc", out_pc, 64'h100);
            step();
        end
        out_ready = 1;
        #1 check("bp_release_ready", in_ready, 1);
        step();
        check("bp_nobubble_valid", out_valid, 1);
        check("bp_nobubble_pc", out_pc, 64'h104);
        in_valid = 0;
        step();

        // Load-use with held load, then one scoreboard stall
        out_ready = 0;
        set_instr(64'h200, 5'd1, 5'd2, 5'd7, 1, 1, 0, 2'b00, 64'd0, 64'd0, 64'd0);
        step();
        set_instr(64'h204, 5'd7, 5'd0, 5'd8, 1, 0, 0, 2'b00, 64'd0, 64'd0, 64'd0);
        #1 check("lu_held_stall", in_ready, 0);
        step();
        out_ready = 1;
        #1 check("lu_depart_stall", in_ready, 0);
        step();
        check("lu_gone_valid", out_valid, 0);
        check("lu_sb_stall", in_ready, 0);
        step();
        check("lu_accept_ready", in_ready, 1);
        step();
        check("lu_issue_pc", out_pc, 64'h204);
        in_valid = 0;
        step();

        // Branches
        set_instr(64'h300, 5'd3, 5'd4, 5'd0, 0, 0, 1, 2'b01, 64'h8000_0040, 64'h10, 64'h10);
        step();
        check("br_eq_redirect", redirect, 1);
        check("br_eq_pc", redirect_pc, 64'h8000_0040);
        in_valid = 0;
        step();
        check("br_pulse_end", redirect, 0);
        for (int i = 0; i < 6; i++) begin
            set_instr(64'h310 + 64'(i), 5'd3, 5'd4, 5'd0, 0, 0, 1, bt_op[i],
                      64'h9000 + 64'(i * 4), bt_r1[i], bt_r2[i]);
            step();
            check("br_table_redirect", redirect, bt_exp[i]);
            in_valid = 0;
            step();
        end

        // Flush with simultaneous accept; the departing load's count survives
        out_ready = 0;
        set_instr(64'h400, 5'd0, 5'd0, 5'd9, 1, 1, 0, 2'b00, 64'd0, 64'd0, 64'd0);
        step();
        out_ready = 1;
        flush = 1;
        set_instr(64'h404, 5'd1, 5'd2, 5'd10, 1, 0, 0, 2'b00, 64'd0, 64'd5, 64'd6);
        #1 check("flush_blocks", in_ready, 0);
        step();
        check("flush_valid", out_valid, 0);
        check("flush_redirect", redirect, 0);
        flush = 0;
        set_instr(64'h408, 5'd9, 5'd0, 5'd10, 1, 0, 0, 2'b00, 64'd0, 64'd5, 64'd6);
        #1 check("flush_sb_kept", in_ready, 0);
        step();
        check("flush_sb_expired", in_ready, 1);
        step();
        check("flush_after_pc", out_pc, 64'h408);
        in_valid = 0;
        step();

        // Asynchronous reset during a stall
        out_ready = 0;
        set_instr(64'h500, 5'd1, 5'd2, 5'd11, 1, 0, 0, 2'b00, 64'd0, 64'd1, 64'd2);
        step();
        set_instr(64'h504, 5'd1, 5'd2, 5'd12, 1, 0, 0, 2'b00, 64'd0, 64'd1, 64'd2);
        repeat (3) step();
        #1 reset = 0;
        #1;
        check("arst_valid", out_valid, 0);
        check("arst_pc", out_pc, 0);
        check("arst_srca", out_srca, 0);
        check("arst_rd", out_rd, 0);
        check("arst_stat_issued", stat_issued, 0);
        check("arst_stat_stalls", stat_stalls, 0);
        in_valid = 0;
        step();
        reset = 1;
        repeat (2) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
